// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 datapath: fetches an instruction over a
// req/ack port into IR, then steps FETCH/DECODE/EXEC/MEM/WB and drives the
// ALU, memory and register-file controls. Halts on an illegal opcode or when
// a memory request goes unanswered for MEM_TIMEOUT cycles.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic        pc_we,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_dbg,
    output logic [31:0] instret
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] LEGAL_OPC [5] = '{OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_AUIPC, OPC_OP};

    // Timeout fires on the last allowed request cycle; a zero MEM_TIMEOUT disables it.
    localparam bit              TO_EN     = (MEM_TIMEOUT > 0);
    localparam int              TO_LAST_I = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
    localparam logic [TO_W-1:0] TO_LAST   = TO_LAST_I[TO_W-1:0];

    logic [2:0]      state_reg, state_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [31:0]     ir_reg;
    logic [31:0]     instret_reg;
    logic            illegal_reg, bus_err_reg;

    logic [6:0] opcode;
    logic [4:0] opc_hit;
    logic       is_legal, is_load, is_store, is_opimm, is_auipc, is_op;
    logic       req_state, alu_phase, timeout_hit;
    logic       load_ir, retire, set_illegal, set_bus_err;

    assign opcode = ir_reg[6:0];

    // One comparator per supported opcode; any hit makes the instruction legal.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_opc
            assign opc_hit[gi] = (opcode == LEGAL_OPC[gi]);
        end
    endgenerate

    assign is_legal = |opc_hit;
    assign is_load  = opc_hit[0];
    assign is_opimm = opc_hit[1];
    assign is_store = opc_hit[2];
    assign is_auipc = opc_hit[3];
    assign is_op    = opc_hit[4];

    assign req_state   = (state_reg == S_FETCH) || (state_reg == S_MEM);
    assign alu_phase   = (state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB);
    assign timeout_hit = TO_EN && (to_cnt_reg == TO_LAST);

    // Next-state logic; an ack in the final allowed cycle is checked before the timeout.
    always_comb begin
        state_next  = state_reg;
        load_ir     = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    load_ir    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    set_bus_err = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_next = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_EXEC: begin
                state_next = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (is_store) begin
                        retire     = 1'b1;
                        state_next = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timeout_hit) begin
                    set_bus_err = 1'b1;
                    state_next  = S_HALT;
                end
            end
            S_WB: begin
                retire     = 1'b1;
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Wait counter runs only while a request is outstanding; any other cycle clears it.
    always_comb begin
        to_cnt_next = '0;
        if (req_state && !mem_ack) to_cnt_next = to_cnt_reg + 1'b1;
    end

    // State, IR, retire counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            to_cnt_reg  <= '0;
            ir_reg      <= '0;
            instret_reg <= '0;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            to_cnt_reg <= to_cnt_next;
            if (load_ir)     ir_reg      <= mem_rdata;
            if (retire)      instret_reg <= instret_reg + 32'd1;
            if (set_illegal) illegal_reg <= 1'b1;
            if (set_bus_err) bus_err_reg <= 1'b1;
        end
    end

    // Control outputs decoded from state; pc_we also covers the STORE ack cycle.
    always_comb begin
        mem_req      = req_state;
        mem_addr_sel = (state_reg == S_MEM);
        mem_we       = (state_reg == S_MEM) && is_store;
        pc_we        = retire;
        reg_we       = (state_reg == S_WB);
        wb_sel       = (state_reg == S_WB) && is_load;
        alu_a_sel    = alu_phase && is_auipc;
        alu_b_sel    = alu_phase && (is_load || is_store || is_opimm || is_auipc);
        alu_op       = (alu_phase && (is_opimm || is_op)) ? 2'b10 : 2'b00;
    end

    assign ir        = ir_reg;
    assign instret   = instret_reg;
    assign illegal   = illegal_reg;
    assign bus_err   = bus_err_reg;
    assign state_dbg = state_reg;

endmodule
